dmem_line_responder: RTL and testbench

- Memory-side responder for the 256-bit line-fill/write-back interface driven by the data cache controller.
- Holds a line-granular backing store and services one request at a time with a fixed, parameterised latency.
- Returns a single-cycle ack with read data that stays held afterwards.
- Replaces the behavioural data memory in the CPU top level and is the reference target for cache verification.

---
 rtl/dmem_line_responder_if.sv | 31 +++
 rtl/dmem_line_responder.sv | 106 ++++++++++
 tb/tb_dmem_line_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_line_responder_if.sv
// Line-fill / write-back bus between the data cache controller (master)
// and the line-granular memory responder (slave).
//   enable_i  request valid, held by the initiator until ack
//   write_i   1 = write-back, 0 = line fill
//   addr_i    byte address of the line
//   data_i    write-back line data
//   ack_o     single-cycle completion pulse
//   data_o    fill line data, held until the next fill completes
//   busy_o    request in flight
interface dmem_line_responder_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Memory-side responder for the cache line-fill/write-back bus.
// Holds a 2**IDX_W-line backing store and services one request at a time,
// acking LATENCY edges after the request is sampled.
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset (backing store is not reset)
//   bus    slave side of dmem_line_responder_if
module dmem_line_responder #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 9,
    parameter int LATENCY = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dmem_line_responder_if.slave   bus
);
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK,
        TURN
    } state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              req_wr_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [LINE_W-1:0] req_data_q;
    logic              ack_q;
    logic [LINE_W-1:0] rdata_q;
    logic              busy_q;

    logic [LINE_W-1:0] mem_q [DEPTH];

    // Offset bits and bits above the index are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[4:0], bus.addr_i[ADDR_W-1:5+IDX_W]};

    // Completion edge: the captured request is committed here.
    logic commit;
    assign commit = (state_q == BUSY) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_wr_q   <= 1'b0;
            req_idx_q  <= '0;
            req_data_q <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable_i) begin
                        req_wr_q   <= bus.write_i;
                        req_idx_q  <= bus.addr_i[5+IDX_W-1:5];
                        req_data_q <= bus.data_i;
                        cnt_q      <= 8'(LATENCY - 1);
                        busy_q     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                        if (!req_wr_q) begin
                            rdata_q <= mem_q[req_idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= TURN;
                end
                // Turnaround: enable_i is not sampled, absorbing an initiator
                // that holds the request one cycle past ack.
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Backing store has no reset; an aborted write never reaches commit
    // because the async reset forces the FSM back to IDLE.
    always_ff @(posedge clk_i) begin
        if (commit && req_wr_q) begin
            mem_q[req_idx_q] <= req_data_q;
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdata_q;
    assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_line_responder_if #(.ADDR_W(32), .LINE_W(256)) bus_a ();
    dmem_line_responder_if #(.ADDR_W(32), .LINE_W(256)) bus_b ();

    dmem_line_responder #(.LINE_W(256), .ADDR_W(32), .IDX_W(9), .LATENCY(10)) dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    dmem_line_responder #(.LINE_W(256), .ADDR_W(32), .IDX_W(9), .LATENCY(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] L3  = {8{32'hA5A5_0003}};
    logic [255:0] L2  = {8{32'h2222_0002}};
    logic [255:0] L4A = {8{32'h4444_0004}};
    logic [255:0] L4B = {8{32'h4B4B_1004}};
    logic [255:0] L7  = {8{32'h7777_0007}};
    logic [255:0] LDB = {8{32'hDEAD_BEEF}};
    logic [255:0] LX  = {8{32'h0BAD_0BAD}};
    logic [255:0] L1  = {8{32'h1111_AA01}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic en, input logic w,
                         input logic [31:0] a, input logic [255:0] d);
        if (s) begin
            bus_b.enable_i = en; bus_b.write_i = w; bus_b.addr_i = a; bus_b.data_i = d;
        end else begin
            bus_a.enable_i = en; bus_a.write_i = w; bus_a.addr_i = a; bus_a.data_i = d;
        end
    endtask

    function automatic logic ack_of(input logic s);
        return s ? bus_b.ack_o : bus_a.ack_o;
    endfunction

    function automatic logic busy_of(input logic s);
        return s ? bus_b.busy_o : bus_a.busy_o;
    endfunction

    function automatic logic [255:0] data_of(input logic s);
        return s ? bus_b.data_o : bus_a.data_o;
    endfunction

    // Counts edges after the current one until ack is seen (bounded).
    task automatic wait_ack(input logic s, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack_of(s) !== 1'b1 && n < 300);
    endtask

    // Full request; returns during the ack cycle with enable dropped.
    task automatic txn(input logic s, input logic w, input logic [31:0] a,
                       input logic [255:0] d, output int lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(s, 1'b1, w, a, d);
        @(posedge clk);
        wait_ack(s, lat);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n1;
        int n2;
        int extra;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 256'(bus_a.ack_o), 256'(1'b0));
        chk("reset_data", bus_a.data_o, '0);
        chk("reset_busy", 256'(bus_a.busy_o), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Preload through write-backs.
        txn(1'b0, 1'b1, 32'h60, L3, lat);
        chk("preload_lat", 256'(lat), 256'(10));
        chk("write_keeps_data_o", bus_a.data_o, '0);
        txn(1'b0, 1'b1, 32'h40, L2, lat);
        txn(1'b0, 1'b1, 32'h80, L4A, lat);
        txn(1'b0, 1'b1, 32'hE0, L7, lat);

        // Read latency and hold.
        txn(1'b0, 1'b0, 32'h60, '0, lat);
        chk("read_lat", 256'(lat), 256'(10));
        chk("read_ack", 256'(bus_a.ack_o), 256'(1'b1));
        chk("read_busy_in_ack", 256'(bus_a.busy_o), 256'(1'b1));
        chk("read_data", bus_a.data_o, L3);
        @(posedge clk); #1;
        chk("ack_one_cycle", 256'(bus_a.ack_o), 256'(1'b0));
        chk("busy_after_ack", 256'(bus_a.busy_o), 256'(1'b0));
        repeat (4) @(posedge clk);
        #1;
        chk("read_data_hold", bus_a.data_o, L3);

        // Write then read back with address offset bits.
        txn(1'b0, 1'b1, 32'h1E0, LDB, lat);
        chk("wr_data_o_unchanged", bus_a.data_o, L3);
        txn(1'b0, 1'b0, 32'h1FF, '0, lat);
        chk("readback_data", bus_a.data_o, LDB);

        // Back-to-back write-back then fill with enable held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h80, L4B);
        @(posedge clk);
        wait_ack(1'b0, n1);
        chk("b2b_first_lat", 256'(n1), 256'(10));
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'hE0, '0);
        wait_ack(1'b0, n2);
        chk("b2b_ack_gap", 256'(n2 + 1), 256'(13));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_a.ack_o === 1'b1) extra++;
        end
        chk("b2b_no_third_ack", 256'(extra), 256'(0));
        chk("b2b_fill_data", bus_a.data_o, L7);
        txn(1'b0, 1'b0, 32'h80, '0, lat);
        chk("b2b_wb_committed", bus_a.data_o, L4B);

        // Enable held through the turnaround after a read ack.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h60, '0);
        @(posedge clk);
        wait_ack(1'b0, lat);
        chk("hold_read_lat", 256'(lat), 256'(10));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_a.ack_o === 1'b1) extra++;
        end
        chk("hold_no_second_ack", 256'(extra), 256'(0));
        chk("hold_busy_idle", 256'(bus_a.busy_o), 256'(1'b0));
        chk("hold_data", bus_a.data_o, L3);

        // Reset in the middle of a write.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h40, LX);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 256'(bus_a.ack_o), 256'(1'b0));
        chk("midrst_data", bus_a.data_o, '0);
        chk("midrst_busy", 256'(bus_a.busy_o), 256'(1'b0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 32'h40, '0, lat);
        chk("midrst_line_kept", bus_a.data_o, L2);

        // Aliasing with LATENCY=1.
        txn(1'b1, 1'b1, 32'h0000_4020, L1, lat);
        chk("lat1_write_lat", 256'(lat), 256'(1));
        txn(1'b1, 1'b0, 32'h0000_0020, '0, lat);
        chk("lat1_read_lat", 256'(lat), 256'(1));
        chk("alias_data", data_of(1'b1), L1);
        @(posedge clk); #1;
        chk("lat1_ack_pulse", 256'(ack_of(1'b1)), 256'(1'b0));
        chk("lat1_busy", 256'(busy_of(1'b1)), 256'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
